// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions.
//   lc3b_word      : 16-bit data/address word
//   lc3b_mem_wmask : 2-bit byte-enable mask
//   arb_state_t    : mem_arbiter FSM states
//   arb_src_t      : requester identity remembered for round-robin
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        SRC_INST,
        SRC_DATA
    } arb_src_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical-memory port between the cpu's
// instruction and data interfaces. Round-robin, one transaction in flight.
//   clk, reset_n                  : clock (rising edge), async active-low reset
//   inst_* / data_* (in)          : requester strobes, byte enable, addr, wdata
//   inst_resp/rdata, data_resp/rdata (out) : completion pulse and read data
//   pmem_* (out)                  : memory strobes / be / addr / wdata, from latches
//   pmem_resp, pmem_rdata (in)    : memory completion and read data
module mem_arbiter
    import lc3b_types::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          inst_read,
    input  logic          inst_write,
    input  lc3b_mem_wmask inst_byte_enable,
    input  lc3b_word      inst_addr,
    input  lc3b_word      inst_wdata,
    output logic          inst_resp,
    output lc3b_word      inst_rdata,

    input  logic          data_read,
    input  logic          data_write,
    input  lc3b_mem_wmask data_byte_enable,
    input  lc3b_word      data_addr,
    input  lc3b_word      data_wdata,
    output logic          data_resp,
    output lc3b_word      data_rdata,

    output logic          pmem_read,
    output logic          pmem_write,
    output lc3b_mem_wmask pmem_byte_enable,
    output lc3b_word      pmem_addr,
    output lc3b_word      pmem_wdata,
    input  logic          pmem_resp,
    input  lc3b_word      pmem_rdata
);

    arb_state_t    state;
    arb_src_t      last_grant;
    logic          lat_read;
    logic          lat_write;
    lc3b_mem_wmask lat_be;
    lc3b_word      lat_addr;
    lc3b_word      lat_wdata;

    logic req_inst;
    logic req_data;
    logic grant_inst;
    logic grant_data;

    assign req_inst = inst_read | inst_write;
    assign req_data = data_read | data_write;

    // On contention the side that did not win last time gets the grant.
    assign grant_inst = req_inst & (~req_data | (last_grant == SRC_DATA));
    assign grant_data = req_data & ~grant_inst;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= DATA_FIRST ? SRC_INST : SRC_DATA;
            lat_read   <= 1'b0;
            lat_write  <= 1'b0;
            lat_be     <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // read+write together is treated as a write
                    if (grant_inst) begin
                        state      <= SERVE_I;
                        last_grant <= SRC_INST;
                        lat_read   <= inst_read & ~inst_write;
                        lat_write  <= inst_write;
                        lat_be     <= inst_byte_enable;
                        lat_addr   <= inst_addr;
                        lat_wdata  <= inst_wdata;
                    end else if (grant_data) begin
                        state      <= SERVE_D;
                        last_grant <= SRC_DATA;
                        lat_read   <= data_read & ~data_write;
                        lat_write  <= data_write;
                        lat_be     <= data_byte_enable;
                        lat_addr   <= data_addr;
                        lat_wdata  <= data_wdata;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        pmem_read        = (state != IDLE) & lat_read;
        pmem_write       = (state != IDLE) & lat_write;
        pmem_byte_enable = lat_be;
        pmem_addr        = lat_addr;
        pmem_wdata       = lat_wdata;

        inst_resp  = (state == SERVE_I) & pmem_resp;
        data_resp  = (state == SERVE_D) & pmem_resp;
        inst_rdata = (state == SERVE_I) ? pmem_rdata : '0;
        data_rdata = (state == SERVE_D) ? pmem_rdata : '0;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified physical-memory port between the cpu's instruction and data memory interfaces.
- Sits between `cpu` and physical memory (later the L2 / cache) inside `mp3`.
- Requests are arbitrated round-robin, one transaction outstanding at a time.
- Request attributes are latched at grant; the memory side sees stable, registered-source strobes.

Parameters:
- DATA_FIRST, 1: grant winner on simultaneous requests when no history exists (after reset). 1 = data, 0 = instruction.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- inst_read, inst_write  in  1 each  instruction-side strobes
- inst_byte_enable  in  lc3b_mem_wmask (2)  instruction-side byte enable
- inst_addr, inst_wdata  in  lc3b_word (16) each  instruction-side address / write data
- inst_resp  out  1  instruction transaction complete
- inst_rdata  out  lc3b_word  instruction read data
- data_read, data_write, data_byte_enable, data_addr, data_wdata  in  as inst_*  data-side request
- data_resp  out  1  data transaction complete
- data_rdata  out  lc3b_word  data read data
- pmem_read, pmem_write  out  1 each  memory strobes
- pmem_byte_enable  out  lc3b_mem_wmask  memory byte enable
- pmem_addr, pmem_wdata  out  lc3b_word  memory address / write data
- pmem_resp  in  1  memory completion
- pmem_rdata  in  lc3b_word  memory read data

Behaviour:
- FSM states: IDLE, SERVE_I, SERVE_D. Reset state is IDLE.
- State register: state, last_grant (1 bit; reset value = !DATA_FIRST encoded as "inst" when DATA_FIRST=1).
- Latched request registers: lat_read, lat_write, lat_be, lat_addr, lat_wdata. All reset to 0.
- Requester valid: req_x = x_read | x_write.
- IDLE:
  - Only inst valid -> SERVE_I. Only data valid -> SERVE_D.
  - Both valid -> grant the side NOT equal to last_grant.
  - On grant: latch that side's strobes, be, addr and wdata; set last_grant to that side.
- If both read and write are asserted, the request is a write: lat_read = 0, lat_write = 1.
- Memory-side outputs:
  - pmem_read = (state != IDLE) & lat_read.
  - pmem_write = (state != IDLE) & lat_write.
  - pmem_addr, pmem_wdata and pmem_byte_enable are driven from the latches and held constant throughout SERVE_x.
- SERVE_x:
  - Wait for pmem_resp.
  - When pmem_resp = 1: x_resp = 1 in that same cycle (combinational); next state is IDLE.
  - The other side's resp stays 0.
- Read data:
  - x_rdata = pmem_rdata whenever state == SERVE_x; otherwise 0.
- Latency:
  - Request seen in cycle 0 -> pmem strobe from cycle 1 -> resp in the pmem_resp cycle.
  - There is a minimum of one IDLE cycle between consecutive transactions. This guarantees the requester has dropped its strobe after seeing resp.
- pmem_resp while in IDLE is ignored; no resp is generated.
- Requester deasserting mid-SERVE: the memory transaction still completes, and resp still pulses once.
- Requester changing addr/wdata mid-SERVE has no effect, because the latches are used.
- Fairness: with both sides continuously requesting, grants alternate I, D, I, D. Neither side waits more than one transaction.
- Async reset mid-transaction: state goes to IDLE and all pmem strobes / resps drop to 0 immediately. An in-flight pmem_resp after reset release is ignored.
- All resp outputs reset to 0; all rdata outputs reset to 0.

Decomposition:
- Already in lc3b_types: lc3b_word, lc3b_mem_wmask.
- Add to lc3b_types:
  - `arb_state_t` enum {IDLE, SERVE_I, SERVE_D}.
  - `arb_src_t` enum {SRC_INST, SRC_DATA} for last_grant.
- No sub-module is needed. The single FSM plus latch register block stays within one module, in roughly 150 lines.

Test Plan:
- Single inst read of addr 0x1000 with pmem_resp after 3 cycles (pmem_rdata = 0xBEEF) -> pmem_read high cycles 1–3, pmem_addr = 0x1000, inst_resp pulses once in cycle 3 with inst_rdata = 0xBEEF, data_resp stays 0.
- Simultaneous inst read 0x2000 and data write 0x3000 (wdata 0x1234, be 2'b01) after reset with DATA_FIRST = 1:
  - data is served first: pmem_write = 1, be = 01, wdata = 0x1234;
  - then one IDLE cycle;
  - then the inst read at 0x2000.
- Both sides held requesting for 6 transactions -> grant order D, I, D, I, D, I; each resp pulse is exactly 1 cycle.
- Data side changes data_addr from 0x4000 to 0x5000 during SERVE_D -> pmem_addr stays 0x4000 until resp.
- reset_n asserted low during SERVE_I with pmem_read high -> pmem_read = 0 asynchronously, state IDLE; a stray pmem_resp after release produces no resp.
- Inst request with read and write both high (be 2'b11) -> pmem_write = 1, pmem_read = 0, inst_resp on completion.
